blink_sequencer: RTL and testbench

Step sequencer that drives the board LEDs from a small programmable pattern table, timed by an internal enable-gated prescaler. Each table entry holds an LED value and a duration in prescaler ticks. The sequencer walks entries 0..last_step, holding each for its duration. It sits between the host/config logic, which writes the table and issues start/stop/pause, and the LED pins.

---
 rtl/blink_sequencer.sv | 159 +++++++++++++++
 tb/tb_blink_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_sequencer.sv
// LED step sequencer: walks a programmable {led, dur} table, timed by an internal prescaler.
// Define BLINK_SEQ_LOOP_EN to wrap back to entry 0 forever instead of a single pass ending in done.
module blink_sequencer #(
    parameter int unsigned PRESCALE = 12_000,
    parameter int unsigned STEPS    = 8,
    parameter int unsigned LED_W    = 3,
    parameter int unsigned DUR_W    = 8,
    localparam int unsigned AW      = $clog2(STEPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    input  logic [AW-1:0]          last_step,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [LED_W+DUR_W-1:0] wr_data,
    output logic [LED_W-1:0]       led,
    output logic [AW-1:0]          step,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned EW = LED_W + DUR_W;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     pcnt, pcnt_n;
    logic [DUR_W-1:0]  dcnt, dcnt_n;
    logic [AW-1:0]     last_q, last_n;
    logic [AW-1:0]     step_n;
    logic [LED_W-1:0]  led_n;
    logic              busy_n;
    logic              done_n;

    logic [EW-1:0]     tbl [STEPS];
    logic [EW-1:0]     ent0;
    logic [EW-1:0]     entn;

    // A zero duration is treated as a one-tick step.
    function automatic logic [DUR_W-1:0] eff_dur(input logic [EW-1:0] e);
        return (e[DUR_W-1:0] == '0) ? DUR_W'(1) : e[DUR_W-1:0];
    endfunction

    assign ent0 = tbl[0];
    assign entn = tbl[step + AW'(1)];

    // Pattern table; reads see the value from before a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl[i] <= '0;
            end
        end else if (wr_en) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pcnt   <= '0;
            dcnt   <= '0;
            last_q <= '0;
            step   <= '0;
            led    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            pcnt   <= pcnt_n;
            dcnt   <= dcnt_n;
            last_q <= last_n;
            step   <= step_n;
            led    <= led_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        dcnt_n  = dcnt;
        last_n  = last_q;
        step_n  = step;
        led_n   = led;
        done_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_RUN;
                    step_n  = '0;
                    led_n   = ent0[EW-1:DUR_W];
                    dcnt_n  = eff_dur(ent0);
                    pcnt_n  = '0;
                    last_n  = last_step;
                end
            end
            S_RUN, S_PAUSED: begin
                // The cycle pause drops is already a counting cycle.
                if (pause) begin
                    state_n = S_PAUSED;
                end else begin
                    state_n = S_RUN;
                    if (pcnt == PMAX) begin
                        pcnt_n = '0;
                        if (dcnt > DUR_W'(1)) begin
                            dcnt_n = dcnt - DUR_W'(1);
                        end else if (step != last_q) begin
                            step_n = step + AW'(1);
                            led_n  = entn[EW-1:DUR_W];
                            dcnt_n = eff_dur(entn);
                        end else begin
`ifdef BLINK_SEQ_LOOP_EN
                            step_n = '0;
                            led_n  = ent0[EW-1:DUR_W];
                            dcnt_n = eff_dur(ent0);
`else
                            state_n = S_IDLE;
                            step_n  = '0;
                            led_n   = '0;
                            dcnt_n  = '0;
                            done_n  = 1'b1;
`endif
                        end
                    end else begin
                        pcnt_n = pcnt + PW'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // stop overrides everything else in the cycle
        if (stop) begin
            state_n = S_IDLE;
            step_n  = '0;
            led_n   = '0;
            pcnt_n  = '0;
            dcnt_n  = '0;
            done_n  = 1'b0;
        end

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// Randomized bench for blink_sequencer with a cycle-countdown reference model and directed literal checks.
// Expectations follow BLINK_SEQ_LOOP_EN when it is defined for the build.
module tb_blink_sequencer;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned STEPS    = 4;
    localparam int unsigned LED_W    = 3;
    localparam int unsigned DUR_W    = 4;
    localparam int unsigned AW       = 2;
    localparam int unsigned EW       = LED_W + DUR_W;
`ifdef BLINK_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic [AW-1:0] last_step = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [EW-1:0] wr_data = '0;
    logic [LED_W-1:0] led;
    logic [AW-1:0] step;
    logic          busy;
    logic          done;

    blink_sequencer #(
        .PRESCALE(PRESCALE),
        .STEPS(STEPS),
        .LED_W(LED_W),
        .DUR_W(DUR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .pause(pause),
        .last_step(last_step),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .led(led),
        .step(step),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference model: a step is just a count of remaining non-paused cycles.
    bit              m_active;
    int              m_idx;
    int              m_last;
    int              m_rem;
    logic [LED_W-1:0] m_led;
    bit              m_done;
    logic [EW-1:0]   m_tbl [STEPS];

    function automatic int step_cycles(input logic [EW-1:0] e);
        int d;
        d = int'(e[DUR_W-1:0]);
        return ((d == 0) ? 1 : d) * int'(PRESCALE);
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_idx = 0;
        m_last = 0;
        m_rem = 0;
        m_led = '0;
        m_done = 1'b0;
        for (int i = 0; i < STEPS; i++) m_tbl[i] = '0;
    endtask

    task automatic model_load(input int idx);
        m_idx = idx;
        m_led = m_tbl[idx][EW-1:DUR_W];
        m_rem = step_cycles(m_tbl[idx]);
    endtask

    // Predict the effect of the coming clock edge from the inputs now applied.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (stop) begin
                m_active = 1'b0;
                m_led = '0;
                m_idx = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_last = int'(last_step);
                    model_load(0);
                end
            end else if (!pause) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    if (m_idx != m_last) begin
                        model_load(m_idx + 1);
                    end else if (LOOP) begin
                        model_load(0);
                    end else begin
                        m_active = 1'b0;
                        m_led = '0;
                        m_idx = 0;
                        m_done = 1'b1;
                    end
                end
            end
            if (wr_en) m_tbl[wr_addr] = wr_data;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model, then compare all outputs at the falling edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        if (chk_en) begin
            vectors++;
            if (led !== m_led || step !== AW'(m_idx) || busy !== m_active || done !== m_done) begin
                miscompares++;
                $display("FAIL model t=%0t led=%0d/%0d step=%0d/%0d busy=%0b/%0b done=%0b/%0b",
                         $time, led, m_led, step, m_idx, busy, m_active, done, m_done);
            end
        end
    endtask

    task automatic wr(input int a, input logic [EW-1:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic kick(input int last);
        last_step = AW'(last);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    function automatic int run_len(input logic [LED_W-1:0] s [80], input int from, input int n);
        int k;
        k = from;
        while (k < n && s[k] == s[from]) k++;
        return k - from;
    endfunction

    logic [LED_W-1:0] smp [80];
    logic [AW-1:0]    stp [80];
    bit               dn  [80];

    initial begin
        int cnt;
        int pl;
        bit did;
        bit found;

        model_reset();
        repeat (3) tick();
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_step", int'(step), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single pass (or looping passes) over a three-entry table
        wr(0, {3'b001, 4'd2});
        wr(1, {3'b010, 4'd1});
        wr(2, {3'b100, 4'd3});
        wr(3, {3'b111, 4'd1});
        kick(2);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            smp[i] = led;
            dn[i] = done;
            if (done) cnt++;
            tick();
        end
        check("pass_len_001", run_len(smp, 0, 80), 8);
        check("pass_val_010", int'(smp[8]), 2);
        check("pass_len_010", run_len(smp, 8, 80), 4);
        check("pass_val_100", int'(smp[12]), 4);
        check("pass_len_100", run_len(smp, 12, 80), 12);
        check("pass_after_led", int'(smp[24]), LOOP ? 1 : 0);
        check("pass_done_cnt", cnt, LOOP ? 0 : 1);
        check("pass_done_at_end", int'(dn[24]), LOOP ? 0 : 1);
        halt();
        check("stop_led", int'(led), 0);
        check("stop_busy", int'(busy), 0);

        // Pause for 10 cycles, 3 cycles into the 010 step
        kick(2);
        cnt = 0;
        pl = 0;
        did = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (led == 3'b010) cnt++;
            if (cnt == 3 && !did) begin
                did = 1'b1;
                pause = 1'b1;
                pl = 10;
            end else if (pl > 0) begin
                pl--;
                if (pl == 0) pause = 1'b0;
            end
            tick();
        end
        check("pause_len_010", cnt, 14);
        halt();

        // Zero duration behaves as one tick
        wr(0, {3'b011, 4'd0});
        wr(1, {3'b101, 4'd1});
        kick(1);
        for (int i = 0; i < 12; i++) begin
            smp[i] = led;
            tick();
        end
        check("dur0_len", run_len(smp, 0, 12), 4);
        check("dur0_next", int'(smp[4]), 5);
        halt();

        // start and stop together while idle
        last_step = 2'd1;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("startstop_busy", int'(busy), 0);
        tick();
        check("startstop_busy2", int'(busy), 0);

        // start while running is ignored; a write to entry 1 during step 0 shows at step 1
        wr(0, {3'b001, 4'd2});
        wr(1, {3'b010, 4'd1});
        kick(2);
        for (int i = 0; i < 12; i++) begin
            smp[i] = led;
            stp[i] = step;
            if (i == 2) begin
                start = 1'b1;
                last_step = 2'd0;
            end
            if (i == 3) start = 1'b0;
            if (i == 4) begin
                wr_en = 1'b1;
                wr_addr = 2'd1;
                wr_data = {3'b110, 4'd1};
            end
            if (i == 5) wr_en = 1'b0;
            tick();
        end
        check("restart_ignored_step", int'(stp[8]), 1);
        check("late_write_led", int'(smp[8]), 6);
        halt();

        // Asynchronous reset mid-run while 010 is displayed
        wr(1, {3'b010, 4'd1});
        kick(2);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (led == 3'b010) found = 1'b1;
            else tick();
        end
        check("reach_010", int'(found), 1);
        model_step();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_led", int'(led), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_step", int'(step), 0);
        tick();
        rst = 1'b0;
        kick(3);
        check("zero_tbl_led", int'(led), 0);
        check("zero_tbl_busy", int'(busy), 1);
        repeat (20) tick();
        halt();

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(3) == 0);
            stop = ($urandom_range(23) == 0);
            if ($urandom_range(7) == 0) pause = ~pause;
            last_step = AW'($urandom_range(STEPS - 1));
            wr_en = ($urandom_range(4) == 0);
            wr_addr = AW'($urandom_range(STEPS - 1));
            wr_data = EW'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
